// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants, parity helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // PARITY is part of the encoding in every build so both ends of the link
  // agree on the numbering; only parity-enabled builds ever enter it.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-wide valid/ready handshake into the UART transmitter.
// Latency: n/a (signal bundle).
// Backpressure: tx_ready low means the transmitter FIFO is full.
// Signals: tx_data_in (byte), tx_valid (byte valid), tx_ready (room in FIFO).
// Modports: master drives bytes, slave (the transmitter) accepts them.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] tx_data_in;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data_in, output tx_valid, input tx_ready);
  modport slave  (input tx_data_in, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with wrap-around pointers, occupancy count, full/empty flags.
// Latency: first-word fall-through; a written entry is visible on rd_data the next cycle.
// Backpressure: writes while full and reads while empty are ignored.
// Ports: clk, rst (sync active-low), clr (sync active-high flush),
//        wr_en/wr_data, rd_en/rd_data, full, empty.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes serialised as start, 8 data bits LSB first, [parity], stop.
// Latency: byte accepted at edge N into an idle, empty path drives the start bit from edge N+2.
// Backpressure: bus.tx_ready drops when the FIFO is full; frames go out back-to-back while queued.
// Ports: clk, rst (sync active-low), soft_rst (sync active-high, same effect, rst dominates),
//        bus (uart_tx_if.slave byte handshake), tx_data_out (registered serial line, idle high),
//        tx_busy (frame on the line), tx_done (one-cycle pulse after each stop bit).
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit (11-bit frames).
module uart_tx #(
  parameter int CLKS_PER_BIT = 3,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      soft_rst,
  uart_tx_if.slave  bus,
  output logic      tx_data_out,
  output logic      tx_busy,
  output logic      tx_done
);
  import uart_pkg::*;

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  uart_state_e          state;
  logic [CW-1:0]        clk_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 done_evt;
  logic                 cnt_last;
  logic                 push;
  logic                 pop;
  logic                 line_nxt;
  logic [DATA_BITS-1:0] fifo_dat;
  logic                 fifo_full;
  logic                 fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic                 par_bit;
`endif

  assign bus.tx_ready = !fifo_full;
  assign push         = bus.tx_valid && bus.tx_ready;
  assign cnt_last     = (clk_cnt == CNT_LAST);

  // Pop either from idle or on the final stop cycle, so a queued byte
  // starts its frame with no idle gap after the previous stop bit.
  assign pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && cnt_last));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (soft_rst),
    .wr_en   (push),
    .wr_data (bus.tx_data_in),
    .rd_en   (pop),
    .rd_data (fifo_dat),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Line level implied by the current state; registered into tx_data_out
  // so the pin trails the state by one cycle and stays glitch-free.
  always_comb begin
    line_nxt = LINE_IDLE;
    case (state)
      START:   line_nxt = START_BIT;
      DATA:    line_nxt = shreg[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_nxt = par_bit;
`endif
      STOP:    line_nxt = STOP_BIT;
      default: line_nxt = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || soft_rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      done_evt    <= 1'b0;
      tx_data_out <= LINE_IDLE;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit     <= 1'b0;
`endif
    end else begin
      // Output stage: all three outputs lag the state by one cycle, which
      // keeps tx_done aligned with the cycle after the visible stop bit.
      tx_data_out <= line_nxt;
      tx_busy     <= (state != IDLE);
      tx_done     <= done_evt;
      done_evt    <= 1'b0;

      if (state == IDLE) begin
        clk_cnt <= '0;
      end else if (cnt_last) begin
        clk_cnt <= '0;
      end else begin
        clk_cnt <= clk_cnt + CNT_ONE;
      end

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (pop) begin
            shreg   <= fifo_dat;
`ifdef UART_TX_PARITY_EN
            par_bit <= even_parity(fifo_dat);
`endif
            state   <= START;
          end
        end

        START: begin
          if (cnt_last) begin
            state <= DATA;
          end
        end

        DATA: begin
          if (cnt_last) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (cnt_last) begin
            state <= STOP;
          end
        end
`endif

        STOP: begin
          if (cnt_last) begin
            done_evt <= 1'b1;
            bit_cnt  <= '0;
            if (pop) begin
              shreg   <= fifo_dat;
`ifdef UART_TX_PARITY_EN
              par_bit <= even_parity(fifo_dat);
`endif
              state   <= START;
            end else begin
              state   <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: reset hold, table-driven single frames,
// back-to-back burst, soft reset abort, and a full 0..255 loopback decode.
module tb_uart_tx;

  localparam int CPB = 3;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = CPB * NB;

  logic clk      = 1'b0;
  logic rst      = 1'b0;
  logic soft_rst = 1'b0;
  logic tx_data_out;
  logic tx_busy;
  logic tx_done;

  uart_tx_if bus();

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .soft_rst    (soft_rst),
    .bus         (bus),
    .tx_data_out (tx_data_out),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  // cyc == k from edge k onward; the negedge after edge k records index k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic line_hist [int];
  logic busy_hist [int];
  logic rdy_hist  [int];
  int   done_q    [$];

  always @(negedge clk) begin
    line_hist[cyc] = tx_data_out;
    busy_hist[cyc] = tx_busy;
    rdy_hist[cyc]  = bus.tx_ready;
    if (tx_done) done_q.push_back(cyc);
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, output int n);
    @(negedge clk);
    bus.tx_data_in = d;
    bus.tx_valid   = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    bus.tx_valid = 1'b0;
  endtask

  // Mid-bit samples of the frame whose start bit is first driven at n+2,
  // packed first-in-time at the top of the NB-bit field.
  function automatic logic [10:0] get_frame(input int n);
    logic [10:0] f;
    f = '0;
    for (int i = 0; i < NB; i++) f = {f[9:0], line_hist[n + 2 + CPB*i + CPB/2]};
    return f;
  endfunction

  function automatic logic [9:0] strip_par(input logic [10:0] f);
`ifdef UART_TX_PARITY_EN
    return {f[10:2], f[0]};
`else
    return f[9:0];
`endif
  endfunction

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // start, d0..d7, stop in time order (MSB first)
    logic       par;
  } vec_t;

  localparam int NV = 8;
  vec_t tbl [NV];

  initial begin
    #1000000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    int          zeros;
    int          ones;
    logic [10:0] f;
    logic [7:0]  rx;
    logic        err;

    tbl[0] = '{8'hA5, 10'b0101001011, 1'b0};
    tbl[1] = '{8'h00, 10'b0000000001, 1'b0};
    tbl[2] = '{8'hFF, 10'b0111111111, 1'b0};
    tbl[3] = '{8'h3C, 10'b0001111001, 1'b0};
    tbl[4] = '{8'h01, 10'b0100000001, 1'b1};
    tbl[5] = '{8'h80, 10'b0000000011, 1'b1};
    tbl[6] = '{8'h07, 10'b0111000001, 1'b1};
    tbl[7] = '{8'h5A, 10'b0010110101, 1'b0};

    bus.tx_data_in = 8'h00;
    bus.tx_valid   = 1'b0;

    // Reset hold with tx_valid toggling.
    repeat (2) @(posedge clk);
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      chk($sformatf("reset_hold_%0d", i), {tx_data_out, tx_busy, bus.tx_ready, tx_done}, 4'b1010);
      bus.tx_valid   = ~bus.tx_valid;
      bus.tx_data_in = 8'(i * 37);
    end
    @(negedge clk);
    bus.tx_valid = 1'b0;
    rst = 1'b1;
    n = cyc;
    wait_until(n + 12);
    ones = 0;
    for (int i = n + 1; i <= n + 10; i++) ones += (line_hist[i] && !busy_hist[i]) ? 1 : 0;
    chk("post_reset_idle", ones, 10);

    // Table-driven single frames.
    for (int k = 0; k < NV; k++) begin
      done_q.delete();
      send(tbl[k].data, n);
      wait_until(n + FRAME + 6);
      f = get_frame(n);
      chk($sformatf("latency_%02h", tbl[k].data), {line_hist[n+1], line_hist[n+2]}, 2'b10);
      chk($sformatf("frame_%02h", tbl[k].data), strip_par(f), tbl[k].frame);
`ifdef UART_TX_PARITY_EN
      chk($sformatf("parity_%02h", tbl[k].data), f[1], tbl[k].par);
`endif
      chk($sformatf("busy_edges_%02h", tbl[k].data),
          {busy_hist[n+1], busy_hist[n+2], busy_hist[n+1+FRAME], busy_hist[n+2+FRAME]}, 4'b0110);
      chk($sformatf("done_count_%02h", tbl[k].data), done_q.size(), 1);
      chk($sformatf("done_delay_%02h", tbl[k].data), (done_q.size() == 1) ? done_q[0] - n : -1, 2 + FRAME);
    end

    // Five writes on consecutive cycles: one in flight plus four queued.
    done_q.delete();
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      bus.tx_data_in = tbl[k].data;
      bus.tx_valid   = 1'b1;
      chk($sformatf("burst_ready_pre_%0d", k), bus.tx_ready, 1);
      @(posedge clk);
      #1;
      if (k == 0) n = cyc;
      @(negedge clk);
    end
    bus.tx_valid = 1'b0;
    chk("burst_ready_full", bus.tx_ready, 0);
    wait_until(n + 5*FRAME + 8);
    chk("burst_ready_reassert", {rdy_hist[n+FRAME], rdy_hist[n+FRAME+1]}, 2'b01);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("burst_frame_%0d", k), strip_par(get_frame(n + FRAME*k)), tbl[k].frame);
      chk($sformatf("burst_boundary_%0d", k), {line_hist[n+FRAME*k+1], line_hist[n+FRAME*k+2]}, 2'b10);
    end
    chk("burst_done_count", done_q.size(), 5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("burst_done_%0d", k), (done_q.size() > k) ? done_q[k] - n : -1, 2 + FRAME*(k+1));
    zeros = 0;
    for (int i = n + 2; i <= n + 1 + 5*FRAME; i++) zeros += busy_hist[i] ? 0 : 1;
    chk("burst_busy_gapless", zeros, 0);
    chk("burst_busy_end", busy_hist[n+2+5*FRAME], 0);

    // Soft reset during DATA of 8'h3C with two bytes queued behind it.
    done_q.delete();
    @(negedge clk);
    bus.tx_data_in = 8'h3C;
    bus.tx_valid   = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    bus.tx_data_in = 8'h11;
    @(posedge clk);
    #1;
    bus.tx_data_in = 8'h22;
    @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
    wait_until(n + 8);
    soft_rst = 1'b1;
    @(negedge clk);
    soft_rst = 1'b0;
    wait_until(n + 70);
    chk("srst_line_edge", {line_hist[n+8], line_hist[n+9]}, 2'b01);
    chk("srst_busy_ready", {busy_hist[n+8], busy_hist[n+9], rdy_hist[n+9]}, 3'b101);
    chk("srst_no_done", done_q.size(), 0);
    ones = 0;
    for (int i = n + 9; i <= n + 68; i++) ones += (line_hist[i] && !busy_hist[i]) ? 1 : 0;
    chk("srst_fifo_flushed", ones, 60);

    // Loopback decode of every byte value.
    for (int b = 0; b < 256; b++) begin
      send(8'(b), n);
      wait_until(n + FRAME + 4);
      f = get_frame(n);
      for (int i = 0; i < 8; i++) rx[i] = f[NB-2-i];
      err = f[NB-1] || !f[0];
`ifdef UART_TX_PARITY_EN
      err = err || (f[1] != ^rx);
`endif
      chk($sformatf("loop_data_%02h", b), rx, b);
      chk($sformatf("loop_err_%02h", b), err, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
